// File: rtl/store_merge_pkg.sv
// store_merge_pkg: shared definitions for the sub-word store engine.
// Holds store size codes, FSM state encoding and the alignment check.
package store_merge_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   // low: the address byte-offset bits, zero-extended to 8 bits.
   // Reserved size behaves as a full word.
   function automatic logic is_aligned(
      input logic [1:0] size,
      input logic [7:0] low
   );
      case (size)
         SZ_HALF: return ~low[0];
         SZ_BYTE: return 1'b1;
         default: return (low == 8'd0);
      endcase
   endfunction

   function automatic logic is_subword(input logic [1:0] size);
      return (size == SZ_HALF) || (size == SZ_BYTE);
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: places a byte/halfword into its lane of a word.
// Ports: old_word, new_data (right-justified), size, offset -> merged.
module store_lane_merge
   import store_merge_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_data,
   input  logic [1:0]        size,
   input  logic [OFF_W-1:0]  offset,
   output logic [DATA_W-1:0] merged
);

   logic [DATA_W-1:0] lane_mask;
   logic [DATA_W-1:0] placed_mask;
   logic [DATA_W-1:0] placed_data;
   logic [OFF_W+2:0]  shift;

   always_comb begin
      lane_mask = '1;
      shift     = {offset, 3'b000};
      case (size)
         SZ_BYTE: lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
         SZ_HALF: lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
         default: lane_mask = '1;
      endcase
      placed_mask = lane_mask << shift;
      placed_data = (new_data & lane_mask) << shift;
      merged      = (old_word & ~placed_mask) | placed_data;
   end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: read-modify-write engine for byte/half/word stores.
// Ports: req_* store request, mem_* memory port, done/misalign_err/busy.
module store_merge_unit
   import store_merge_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [1:0]        req_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_wack,
   output logic              done,
   output logic              misalign_err,
   output logic              busy
);

   localparam int OFF_W = $clog2(DATA_W / 8);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        size_q, size_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] merged;
   logic [7:0]        req_low;

   assign req_low = 8'(req_addr[OFF_W-1:0]);

   store_lane_merge #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_lane_merge (
      .old_word (rdata_q),
      .new_data (data_q),
      .size     (size_q),
      .offset   (addr_q[OFF_W-1:0]),
      .merged   (merged)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      rdata_d = rdata_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d = req_addr;
               data_d = req_data;
               size_d = req_size;
               if (!is_aligned(req_size, req_low)) begin
                  state_d = ST_ERR;
               end else if (is_subword(req_size)) begin
                  state_d = ST_READ;
               end else begin
                  // full word needs no read: write data directly
                  wdata_d = req_data;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_READ: begin
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               state_d = ST_MERGE;
            end
         end
         ST_MERGE: begin
            wdata_d = merged;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_wack) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
      end
   end

   // Strobes decode straight from state so reset drops them at once.
   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign mem_re       = (state_q == ST_READ);
   assign mem_we       = (state_q == ST_WRITE);
   assign done         = (state_q == ST_DONE);
   assign misalign_err = (state_q == ST_ERR);
   assign mem_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: randomized self-checking bench for store_merge_unit.
// Drives a 32-bit and a 64-bit instance against a byte-level model.
module tb_store_merge_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   always #5 clk = ~clk;

   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_data;
   logic [1:0]  req_size;
   logic [31:0] mem_addr, mem_rdata, mem_wdata;
   logic        mem_re, mem_rvalid, mem_we, mem_wack;
   logic        done, misalign_err, busy;

   logic        w_req_valid, w_req_ready;
   logic [31:0] w_req_addr, w_mem_addr;
   logic [63:0] w_req_data, w_mem_rdata, w_mem_wdata;
   logic [1:0]  w_req_size;
   logic        w_mem_re, w_mem_rvalid, w_mem_we, w_mem_wack;
   logic        w_done, w_misalign_err, w_busy;

   int total = 0;
   int bad   = 0;

   store_merge_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_wack(mem_wack), .done(done), .misalign_err(misalign_err),
      .busy(busy)
   );

   store_merge_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_addr(w_req_addr), .req_data(w_req_data), .req_size(w_req_size),
      .mem_addr(w_mem_addr), .mem_re(w_mem_re), .mem_rvalid(w_mem_rvalid),
      .mem_rdata(w_mem_rdata), .mem_we(w_mem_we), .mem_wdata(w_mem_wdata),
      .mem_wack(w_mem_wack), .done(w_done), .misalign_err(w_misalign_err),
      .busy(w_busy)
   );

   function automatic int size_bytes(logic [1:0] sz, int wbytes);
      if (sz == 2'b01) return 2;
      if (sz == 2'b10) return 1;
      return wbytes;
   endfunction

   function automatic bit model_ok(logic [1:0] sz, logic [31:0] a,
                                   int wbytes);
      return (a % size_bytes(sz, wbytes)) == 0;
   endfunction

   function automatic logic [63:0] model_merge(logic [63:0] old,
      logic [63:0] d, logic [1:0] sz, logic [31:0] a, int wbytes);
      int nb, k;
      logic [63:0] r;
      nb = size_bytes(sz, wbytes);
      k  = a % wbytes;
      r  = old;
      for (int i = 0; i < nb; i++) r[8*(k+i) +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic run_store(
      input  logic [31:0] a, d,
      input  logic [1:0]  sz,
      input  logic [31:0] rd,
      input  int          rlat, wlat,
      input  bit          hold,
      output logic [31:0] wd_obs, ad_obs,
      output int          lat, re_n, we_n,
      output bit          err, rdy_bad
   );
      int rc, wc;
      wd_obs = '0; ad_obs = '0; lat = -1; re_n = 0; we_n = 0;
      err = 0; rdy_bad = 0; rc = 0; wc = 0;
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
      @(posedge clk); #1;
      if (!hold) begin
         req_valid = 1'b0; req_addr = $urandom; req_data = $urandom;
      end
      for (int c = 1; c <= 40; c++) begin
         if (req_ready || !busy) rdy_bad = 1;
         if (done) begin lat = c; break; end
         if (misalign_err) begin err = 1; lat = c; break; end
         if (mem_re) begin
            re_n++; ad_obs = mem_addr;
            mem_rvalid = (rc == rlat);
            mem_rdata  = (rc == rlat) ? rd : $urandom;
            mem_wack   = 1'($urandom % 2);
            rc++;
         end else if (mem_we) begin
            we_n++; wd_obs = mem_wdata; ad_obs = mem_addr;
            mem_wack   = (wc == wlat);
            mem_rvalid = 1'($urandom % 2);
            mem_rdata  = $urandom;
            wc++;
         end else begin
            mem_rvalid = 1'($urandom % 2);
            mem_wack   = 1'($urandom % 2);
            mem_rdata  = $urandom;
         end
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0; mem_wack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid = 0; req_addr = 0; req_data = 0; req_size = 0;
      mem_rvalid = 0; mem_rdata = 0; mem_wack = 0;
      w_req_valid = 0; w_req_addr = 0; w_req_data = 0; w_req_size = 0;
      w_mem_rvalid = 0; w_mem_rdata = 0; w_mem_wack = 0;
      #1;
      total++;
      if ({req_ready, mem_re, mem_we, done, misalign_err, busy}
          !== 6'b100000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=100000",
            {req_ready, mem_re, mem_we, done, misalign_err, busy});
      end
      total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus addr=%h wdata=%h want 0", mem_addr,
            mem_wdata);
      end
      total++;
      if ({w_req_ready, w_busy, w_mem_re, w_mem_we} !== 4'b1000 ||
          w_mem_wdata !== 64'h0) begin
         bad++;
         $display("FAIL reset_w64 flags=%b wdata=%h",
            {w_req_ready, w_busy, w_mem_re, w_mem_we}, w_mem_wdata);
      end
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] wd, ad; int lat, rn, wn; bit er, rb;
      run_store(32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 0, 0, 0,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (rn !== 0 || wn !== 1 || er || rb) begin
         bad++;
         $display("FAIL word_strobes re=%0d we=%0d err=%0d rdy=%0d want 0 1 0 0",
            rn, wn, er, rb);
      end
      total++;
      if (wd !== 32'hDEADBEEF || ad !== 32'h100) begin
         bad++;
         $display("FAIL word_data wdata=%h addr=%h want deadbeef 100", wd, ad);
      end
      total++;
      if (lat !== 2) begin
         bad++;
         $display("FAIL word_latency got=%0d want=2", lat);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h100};
      logic [31:0] wd, ad; int lat, rn, wn; bit er, rb;
      for (int i = 0; i < 3; i++) begin
         run_store(addrs[i], 32'hAA, 2'b10, 32'h11223344, 0, 0, 0,
                   wd, ad, lat, rn, wn, er, rb);
         total++;
         if (wd !== 32'(model_merge(64'h11223344, 64'hAA, 2'b10,
                                   addrs[i], 4)) ||
             ad !== 32'h100 || lat !== 4) begin
            bad++;
            $display("FAIL byte_lane a=%h wdata=%h addr=%h lat=%0d", addrs[i],
               wd, ad, lat);
         end
      end
   endtask

   task automatic test_half();
      logic [31:0] wd, ad; int lat, rn, wn; bit er, rb;
      run_store(32'h102, 32'hBEEF, 2'b01, 32'h11223344, 0, 0, 0,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (wd !== 32'hBEEF3344 || ad !== 32'h100 || er) begin
         bad++;
         $display("FAIL half_lane wdata=%h addr=%h want beef3344 100", wd, ad);
      end
      run_store(32'h103, 32'hBEEF, 2'b01, 32'h11223344, 0, 0, 0,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (!er || lat !== 1 || rn !== 0 || wn !== 0) begin
         bad++;
         $display("FAIL half_misalign err=%0d lat=%0d re=%0d we=%0d",
            er, lat, rn, wn);
      end
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL misalign_idle ready=%b busy=%b want 1 0",
            req_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd, ad, rd; int lat, rn, wn; bit er, rb;
      rd = $urandom;
      run_store(32'h102, 32'h77, 2'b10, rd, 3, 2, 1,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (rn !== 4 || wn !== 3 || rb) begin
         bad++;
         $display("FAIL wait_hold re=%0d we=%0d rdy_bad=%0d want 4 3 0",
            rn, wn, rb);
      end
      total++;
      if (lat !== 9 || wd !== 32'(model_merge(64'(rd), 64'h77, 2'b10,
                                              32'h102, 4))) begin
         bad++;
         $display("FAIL wait_result lat=%0d wdata=%h", lat, wd);
      end
      run_store(32'h200, 32'hCAFEF00D, 2'b11, 32'h0, 0, 0, 0,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (wd !== 32'hCAFEF00D || ad !== 32'h200 || lat !== 2 || rn !== 0) begin
         bad++;
         $display("FAIL second_req wdata=%h addr=%h lat=%0d re=%0d",
            wd, ad, lat, rn);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] wd, ad; int lat, rn, wn; bit er, rb, seen;
      req_valid = 1; req_addr = 32'h104; req_data = 32'h5; req_size = 2'b10;
      @(posedge clk); #1;
      req_valid = 0;
      mem_rvalid = 1; mem_rdata = 32'h0;
      for (int c = 0; c < 10 && !mem_we; c++) begin
         @(posedge clk); #1;
      end
      mem_rvalid = 0;
      total++;
      if (mem_we !== 1'b1) begin
         bad++;
         $display("FAIL reach_write mem_we=%b want 1", mem_we);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_abort we=%b busy=%b ready=%b want 0 0 1",
            mem_we, busy, req_ready);
      end
      @(posedge clk); #3 reset_n = 1'b1;
      mem_wack = 1; mem_rvalid = 1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done || mem_we || mem_re || busy) seen = 1;
      end
      mem_wack = 0; mem_rvalid = 0;
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL stale_resp activity=%b want 0", seen);
      end
      run_store(32'h10A, 32'h1234, 2'b01, 32'hA5A5A5A5, 1, 1, 0,
                wd, ad, lat, rn, wn, er, rb);
      total++;
      if (wd !== 32'h1234A5A5 || lat !== 6) begin
         bad++;
         $display("FAIL after_reset wdata=%h lat=%0d want 1234a5a5 6", wd, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, rd, wd, ad; logic [1:0] sz;
      int rl, wl, lat, rn, wn, elat, ern, ewn; bit er, rb, ok, sub;
      for (int n = 0; n < 40; n++) begin
         a = $urandom; d = $urandom; rd = $urandom; sz = 2'($urandom);
         if (n % 2 == 0) a[1:0] = 2'b00;
         rl = $urandom_range(0, 3); wl = $urandom_range(0, 3);
         run_store(a, d, sz, rd, rl, wl, 0, wd, ad, lat, rn, wn, er, rb);
         ok   = model_ok(sz, a, 4);
         sub  = size_bytes(sz, 4) < 4;
         elat = !ok ? 1 : (sub ? rl + wl + 4 : wl + 2);
         ern  = (ok && sub) ? rl + 1 : 0;
         ewn  = ok ? wl + 1 : 0;
         total++;
         if (er !== !ok || lat !== elat || rn !== ern || wn !== ewn || rb) begin
            bad++;
            $display("FAIL rand_flow a=%h sz=%0d err=%0d lat=%0d/%0d re=%0d/%0d we=%0d/%0d",
               a, sz, er, lat, elat, rn, ern, wn, ewn);
         end
         if (ok) begin
            total++;
            if (wd !== 32'(model_merge(64'(rd), 64'(d), sz, a, 4)) ||
                ad !== {a[31:2], 2'b00}) begin
               bad++;
               $display("FAIL rand_data a=%h sz=%0d wdata=%h addr=%h",
                  a, sz, wd, ad);
            end
         end
      end
   endtask

   task automatic test_w64();
      logic [63:0] exp;
      exp = model_merge(64'h0, 64'h5A, 2'b10, 32'h205, 8);
      w_req_valid = 1; w_req_addr = 32'h205; w_req_data = 64'h5A;
      w_req_size = 2'b10;
      @(posedge clk); #1;
      w_req_valid = 0;
      total++;
      if (w_mem_re !== 1'b1 || w_mem_addr !== 32'h200) begin
         bad++;
         $display("FAIL w64_read re=%b addr=%h want 1 200", w_mem_re,
            w_mem_addr);
      end
      w_mem_rdata = 64'h0; w_mem_rvalid = 1;
      @(posedge clk); #1;
      w_mem_rvalid = 0;
      @(posedge clk); #1;
      total++;
      if (w_mem_we !== 1'b1 || w_mem_wdata !== exp) begin
         bad++;
         $display("FAIL w64_byte we=%b wdata=%h want 1 %h", w_mem_we,
            w_mem_wdata, exp);
      end
      w_mem_wack = 1;
      @(posedge clk); #1;
      w_mem_wack = 0;
      total++;
      if (w_done !== 1'b1) begin
         bad++;
         $display("FAIL w64_done done=%b want 1", w_done);
      end
      @(posedge clk); #1;
      w_req_valid = 1; w_req_addr = 32'h204; w_req_size = 2'b00;
      @(posedge clk); #1;
      w_req_valid = 0;
      total++;
      if (w_misalign_err !== 1'b1 || w_mem_re !== 1'b0 ||
          w_mem_we !== 1'b0) begin
         bad++;
         $display("FAIL w64_misalign err=%b re=%b we=%b want 1 0 0",
            w_misalign_err, w_mem_re, w_mem_we);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_lanes();
      test_half();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_w64();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
